instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 89 ++++++++
 tb/tb_instruction_fetch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding program-memory read,
// a one-entry instruction holding register and jump redirect.
module instruction_fetch #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RST_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rd_data,
  input  logic              mem_rd_valid,
  output logic [15:0]       cell_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [1:0] {
    FETCH_REQ,
    FETCH_WAIT,
    HOLD,
    DRAIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_q;

  // The request must react to halt/jmp_en in the same cycle,
  // so it is decoded from the registered state.
  assign mem_rd_en = (state == FETCH_REQ) && !halt
                     && !jmp_en && !rst;
  assign mem_addr  = pc_q;
  assign pc        = pc_q;

  // Fetch FSM with PC, instruction register and valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH_REQ;
      pc_q        <= RST_VECTOR;
      cell_data   <= 16'h0000;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        FETCH_REQ: begin
          if (jmp_en) begin
            pc_q        <= jmp_addr;
            instr_valid <= 1'b0;
          end else if (!halt) begin
            state <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (jmp_en) begin
            pc_q        <= jmp_addr;
            instr_valid <= 1'b0;
            state       <= mem_rd_valid ? FETCH_REQ : DRAIN;
          end else if (mem_rd_valid) begin
            cell_data   <= mem_rd_data;
            instr_valid <= 1'b1;
            pc_q        <= pc_q + ADDR_W'(1);
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (jmp_en) begin
            pc_q        <= jmp_addr;
            instr_valid <= 1'b0;
            state       <= FETCH_REQ;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= FETCH_REQ;
          end
        end
        DRAIN: begin
          // A redirect here only moves the PC; the stale
          // response still has to be swallowed.
          if (jmp_en)       pc_q  <= jmp_addr;
          if (mem_rd_valid) state <= FETCH_REQ;
        end
        default: state <= FETCH_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios plus
// random traffic against a transaction-level fetch model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst, halt, jmp_en;
  logic [7:0]  jmp_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rd_data;
  logic        mem_rd_valid;
  logic [15:0] cell_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  pc;

  int errors = 0;
  int checks = 0;

  logic [15:0] rom [256];

  // memory responder
  bit          pend = 0;
  int          cnt = 0;
  logic [15:0] pdata;
  int          lat_fix = 1;
  bit          ovr_en = 0;
  logic [15:0] ovr_data;
  bit          keep_rst = 0;

  // reference model: outstanding request / discard / held word
  logic [7:0]  m_pc;
  bit          m_held, m_outst, m_disc;
  logic [15:0] m_data;

  instruction_fetch #(.ADDR_W(8), .RST_VECTOR(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
    .halt         (halt),
    .jmp_en       (jmp_en),
    .jmp_addr     (jmp_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .cell_data    (cell_data),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc           (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit h,
                      input bit j, input logic [7:0] ja,
                      input bit rdy);
    bit v;
    bit exp_en;
    int lat;
    @(negedge clk);
    v            = pend && (cnt == 0);
    rst          = r;
    halt         = h;
    jmp_en       = j;
    jmp_addr     = ja;
    instr_ready  = rdy;
    mem_rd_valid = v;
    mem_rd_data  = v ? pdata : 16'($urandom);
    if (v) pend = 0;
    else if (pend) cnt--;
    if (r && !keep_rst) pend = 0;
    #1;
    exp_en = !r && !m_held && !m_outst && !h && !j;
    chk("rd_en", 32'(mem_rd_en), 32'(exp_en));
    if (exp_en) chk("addr", 32'(mem_addr), 32'(m_pc));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("valid", 32'(instr_valid), 32'(m_held));
    chk("cell", 32'(cell_data), 32'(m_data));
    if (mem_rd_en && !r) begin
      lat   = (lat_fix != 0) ? lat_fix : $urandom_range(1, 4);
      pend  = 1;
      cnt   = lat - 1;
      pdata = ovr_en ? ovr_data : rom[mem_addr];
    end
    if (r) begin
      m_pc = 8'h00; m_held = 0; m_data = 16'h0000;
      m_outst = 0; m_disc = 0;
    end else if (j) begin
      m_pc   = ja;
      m_held = 0;
      if (m_outst && v) begin
        m_outst = 0; m_disc = 0;
      end else if (m_outst) begin
        m_disc = 1;
      end
    end else if (exp_en) begin
      m_outst = 1;
    end else if (m_outst && v) begin
      if (!m_disc) begin
        m_data = mem_rd_data;
        m_held = 1;
        m_pc   = m_pc + 8'd1;
      end
      m_outst = 0;
      m_disc  = 0;
    end else if (m_held && rdy) begin
      m_held = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    rom[8'h20] = 16'h1234;
    rst = 1; halt = 0; jmp_en = 0; jmp_addr = 0;
    instr_ready = 0; mem_rd_valid = 0; mem_rd_data = 0;
    repeat (2) @(posedge clk);
    m_pc = 8'h00; m_held = 0; m_data = 16'h0000;
    m_outst = 0; m_disc = 0;
    step(1, 0, 0, 8'h00, 0);

    // back-to-back fetches, latency 1, always ready
    for (int c = 1; c <= 9; c++) begin
      step(0, 0, 0, 8'h00, 1);
      if (c % 3 == 1) begin
        chk("seq_en", 32'(mem_rd_en), 32'd1);
        chk("seq_addr", 32'(mem_addr), 32'((c - 1) / 3));
      end else begin
        chk("seq_idle", 32'(mem_rd_en), 32'd0);
      end
      if (c % 3 == 0)
        chk("seq_cell", 32'(cell_data), 32'(rom[c / 3 - 1]));
    end

    // decoder stalls for 5 cycles
    step(0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0, 8'h00, 0);
      chk("stall_en", 32'(mem_rd_en), 32'd0);
      chk("stall_v", 32'(instr_valid), 32'd1);
      chk("stall_cell", 32'(cell_data), 32'(rom[3]));
      chk("stall_pc", 32'(pc), 32'd4);
    end
    step(0, 0, 0, 8'h00, 1);

    // jump to the top address, then wrap
    step(0, 0, 1, 8'hFF, 0);
    chk("jmp_no_req", 32'(mem_rd_en), 32'd0);
    step(0, 0, 0, 8'h00, 0);
    chk("ff_addr", 32'(mem_addr), 32'h0FF);
    step(0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 1);
    chk("wrap_pc", 32'(pc), 32'h000);
    chk("ff_cell", 32'(cell_data), 32'(rom[8'hFF]));

    // redirect while waiting, stale BEEF arrives later
    lat_fix = 4; ovr_en = 1; ovr_data = 16'hBEEF;
    step(0, 0, 0, 8'h00, 0);
    chk("wrap_addr", 32'(mem_addr), 32'h000);
    lat_fix = 1; ovr_en = 0;
    step(0, 0, 1, 8'h20, 0);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 8'h00, 0);
      chk("no_beef", 32'(cell_data == 16'hBEEF), 32'd0);
    end
    step(0, 0, 0, 8'h00, 0);
    chk("redir_addr", 32'(mem_addr), 32'h020);
    chk("no_beef", 32'(cell_data == 16'hBEEF), 32'd0);

    // jump coincident with the response
    step(0, 0, 1, 8'h40, 0);
    chk("coinc_vld", 32'(mem_rd_valid), 32'd1);
    step(0, 0, 0, 8'h00, 0);
    chk("coinc_en", 32'(mem_rd_en), 32'd1);
    chk("coinc_addr", 32'(mem_addr), 32'h040);
    chk("coinc_v", 32'(instr_valid), 32'd0);
    step(0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 1);

    // halt blocks requests; reset abandons an in-flight read
    for (int c = 0; c < 4; c++) begin
      step(0, 1, 0, 8'h00, 0);
      chk("halt_en", 32'(mem_rd_en), 32'd0);
    end
    lat_fix = 3; keep_rst = 1;
    step(0, 0, 0, 8'h00, 0);
    chk("pre_rst_addr", 32'(mem_addr), 32'h041);
    step(1, 1, 0, 8'h00, 0);
    step(0, 1, 0, 8'h00, 0);
    chk("rst_pc", 32'(pc), 32'h000);
    chk("rst_v", 32'(instr_valid), 32'd0);
    step(0, 1, 0, 8'h00, 0);
    chk("stale_vld", 32'(mem_rd_valid), 32'd1);
    step(0, 1, 0, 8'h00, 0);
    chk("stale_ign", 32'(instr_valid), 32'd0);
    lat_fix = 0; keep_rst = 0;
    step(0, 0, 0, 8'h00, 0);
    chk("post_rst_addr", 32'(mem_addr), 32'h000);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0),
           8'($urandom),
           ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
